// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control slice.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID    = 2'b11;
    localparam int         TIMEOUT_DEFAULT = 30;
    localparam int         CNT_W_DEFAULT   = 5;

    // Address 3 selects no port, so it maps to an all-zero vector.
    function automatic logic [2:0] port_onehot(input logic [1:0] a);
        port_onehot = (a == ADDR_INVALID) ? 3'b000 : (3'b001 << a);
    endfunction

endpackage

// File: rtl/router_if.sv
// Bundle of the router control signals shared by input port, register block and FIFOs.
interface router_if;
    logic       pkt_valid;
    logic [1:0] addr;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full_in;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       full_state;
    logic       laf_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic       busy;
    logic       fifo_full;
    logic [2:0] write_enb;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;

    modport master (
        output pkt_valid, addr, parity_done, low_pkt_valid, fifo_full_in, fifo_empty, read_enb,
        input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, fifo_full, write_enb, vld_out, soft_reset
    );

    modport slave (
        input  pkt_valid, addr, parity_done, low_pkt_valid, fifo_full_in, fifo_empty, read_enb,
        output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
               write_enb_reg, busy, fifo_full, write_enb, vld_out, soft_reset
    );
endinterface

// File: rtl/router_timeout.sv
// Read-timeout for one output port: pulses soft_reset after TIMEOUT unread valid cycles.
module router_timeout #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= 1'b0;
            if (!vld || rd) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                cnt        <= '0;
                soft_reset <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ctrl.sv
// Control FSM of the 1x3 router: packet sequencing, FIFO write enables and read timeouts.
//   state              | meaning
//   DECODE_ADDRESS     | idle, waiting for a header with a valid port
//   LOAD_FIRST_DATA    | header byte written to FIFO
//   LOAD_DATA          | payload bytes streaming into FIFO
//   LOAD_PARITY        | parity byte written after pkt_valid drops
//   FIFO_FULL_STATE    | destination FIFO full, input stalled
//   LOAD_AFTER_FULL    | write of the byte held while full
//   WAIT_TILL_EMPTY    | destination FIFO busy with an earlier packet
//   CHECK_PARITY_ERROR | register block compares parity
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input logic      clk,
    input logic      rst,
    router_if.slave  bus
);

    state_t     state;
    logic [1:0] addr_reg;
    logic [2:0] soft_reset;
    logic       addr_ok;
    logic       sr_hit;
    logic       full_sel;

    assign addr_ok  = bus.pkt_valid && (bus.addr != ADDR_INVALID);
    assign sr_hit   = |(soft_reset & port_onehot(addr_reg));
    assign full_sel = |(bus.fifo_full_in & port_onehot(addr_reg));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= 2'b00;
        end else begin
            if (state == DECODE_ADDRESS && addr_ok)
                addr_reg <= bus.addr;

            // An abandoned destination FIFO aborts whatever packet is in flight.
            if (state != DECODE_ADDRESS && sr_hit) begin
                state <= DECODE_ADDRESS;
            end else begin
                case (state)
                    DECODE_ADDRESS:
                        if (addr_ok)
                            state <= (|(bus.fifo_empty & port_onehot(bus.addr)))
                                     ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    LOAD_FIRST_DATA:
                        state <= LOAD_DATA;
                    LOAD_DATA:
                        if (full_sel)            state <= FIFO_FULL_STATE;
                        else if (!bus.pkt_valid) state <= LOAD_PARITY;
                    FIFO_FULL_STATE:
                        if (!full_sel)           state <= LOAD_AFTER_FULL;
                    LOAD_AFTER_FULL:
                        if (bus.parity_done)        state <= DECODE_ADDRESS;
                        else if (bus.low_pkt_valid) state <= LOAD_PARITY;
                        else                        state <= LOAD_DATA;
                    LOAD_PARITY:
                        state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR:
                        state <= full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    WAIT_TILL_EMPTY:
                        if (|(bus.fifo_empty & port_onehot(addr_reg)))
                            state <= LOAD_FIRST_DATA;
                    default:
                        state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY)
                             || (state == LOAD_AFTER_FULL);
    assign bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    assign bus.fifo_full     = full_sel;
    assign bus.write_enb     = bus.write_enb_reg ? port_onehot(addr_reg) : 3'b000;
    assign bus.vld_out       = ~bus.fifo_empty;
    assign bus.soft_reset    = soft_reset;

    for (genvar g = 0; g < 3; g++) begin : g_timeout
        router_timeout #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timeout (
            .clk        (clk),
            .rst        (rst),
            .vld        (~bus.fifo_empty[g]),
            .rd         (bus.read_enb[g]),
            .soft_reset (soft_reset[g])
        );
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: directed scenarios then random traffic against a packet-level model.
module tb_router_ctrl;
    localparam int TO = 30;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    router_if bus();

    router_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {M_IDLE, M_FIRST, M_PAYLOAD, M_PARITY, M_FULL, M_AFTER_FULL, M_WAIT, M_CHECK} ms_t;

    ms_t        ms = M_IDLE;
    int         m_port = 0;
    int         run_len [3] = '{0, 0, 0};
    logic [2:0] m_sr = 3'b000;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the packet-level model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [2:0] sr_old;
        logic       full;
        ms_t        nx;
        sr_old = m_sr;
        full   = bus.fifo_full_in[m_port];
        if (!rst) begin
            ms      = M_IDLE;
            m_port  = 0;
            run_len = '{0, 0, 0};
            m_sr    = 3'b000;
            return;
        end
        // A port fires after every full multiple of TO consecutive unread valid cycles.
        for (int i = 0; i < 3; i++) begin
            if (bus.fifo_empty[i] || bus.read_enb[i]) run_len[i] = 0;
            else                                      run_len[i]++;
            m_sr[i] = (run_len[i] > 0) && (run_len[i] % TO == 0);
        end
        nx = ms;
        if (ms != M_IDLE && sr_old[m_port]) nx = M_IDLE;
        else begin
            case (ms)
                M_IDLE:
                    if (bus.pkt_valid && bus.addr != 2'd3) begin
                        m_port = int'(bus.addr);
                        nx = bus.fifo_empty[bus.addr] ? M_FIRST : M_WAIT;
                    end
                M_FIRST:      nx = M_PAYLOAD;
                M_PAYLOAD:    nx = full ? M_FULL : (!bus.pkt_valid ? M_PARITY : M_PAYLOAD);
                M_FULL:       nx = full ? M_FULL : M_AFTER_FULL;
                M_AFTER_FULL: nx = bus.parity_done ? M_IDLE
                                 : (bus.low_pkt_valid ? M_PARITY : M_PAYLOAD);
                M_PARITY:     nx = M_CHECK;
                M_CHECK:      nx = full ? M_FULL : M_IDLE;
                M_WAIT:       nx = bus.fifo_empty[m_port] ? M_FIRST : M_WAIT;
                default:      nx = M_IDLE;
            endcase
        end
        ms = nx;
    endtask

    task automatic check_all();
        logic [7:0] obs;
        logic [7:0] exp;
        logic       wer;
        wer = (ms == M_PAYLOAD) || (ms == M_PARITY) || (ms == M_AFTER_FULL);
        obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
               bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
        exp = {ms == M_IDLE, ms == M_FIRST, ms == M_PAYLOAD, ms == M_FULL,
               ms == M_AFTER_FULL, ms == M_CHECK, wer, !(ms == M_IDLE || ms == M_PAYLOAD)};
        check("state_flags", obs, exp);
        check("write_enb", {5'b0, bus.write_enb}, wer ? 8'(1 << m_port) : 8'h00);
        check("fifo_full", {7'b0, bus.fifo_full}, {7'b0, bus.fifo_full_in[m_port]});
        check("vld_out", {5'b0, bus.vld_out}, {5'b0, ~bus.fifo_empty});
        check("soft_reset", {5'b0, bus.soft_reset}, {5'b0, m_sr});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int p1;
        int p2;
        logic seen;

        rst               = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.addr          = 2'b00;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full_in  = 3'b000;
        bus.fifo_empty    = 3'b111;
        bus.read_enb      = 3'b000;

        step(); step();
        check("reset_detect_add", {7'b0, bus.detect_add}, 8'h01);
        check("reset_busy", {7'b0, bus.busy}, 8'h00);
        rst = 1'b1;

        // Packet to empty port 1 with three payload bytes.
        bus.pkt_valid = 1'b1; bus.addr = 2'b01;
        step();
        check("p1_lfd", {7'b0, bus.lfd_state}, 8'h01);
        bus.addr = 2'b10;
        step(); step(); step();
        check("p1_ld_wen", {5'b0, bus.write_enb}, 8'h02);
        bus.pkt_valid = 1'b0;
        step();
        check("p1_lp_wen", {5'b0, bus.write_enb}, 8'h02);
        step();
        check("p1_cpe", {7'b0, bus.rst_int_reg}, 8'h01);
        step();
        check("p1_cpe_once", {6'b0, bus.rst_int_reg, bus.detect_add}, 8'h01);

        // Invalid address is dropped.
        bus.pkt_valid = 1'b1; bus.addr = 2'b11;
        step();
        check("inv_stay", {6'b0, bus.detect_add, bus.busy}, 8'h02);
        check("inv_wen", {5'b0, bus.write_enb}, 8'h00);

        // Port 2 busy at header.
        bus.fifo_empty = 3'b011; bus.addr = 2'b10;
        step();
        check("wte_busy", {6'b0, bus.detect_add, bus.busy}, 8'h01);
        bus.pkt_valid = 1'b0;
        step();
        bus.fifo_empty = 3'b111;
        step();
        check("wte_to_lfd", {7'b0, bus.lfd_state}, 8'h01);
        step(); step(); step(); step();

        // Full during payload on port 0.
        bus.pkt_valid = 1'b1; bus.addr = 2'b00;
        step(); step();
        bus.fifo_full_in = 3'b001;
        step();
        check("ff_state", {7'b0, bus.full_state}, 8'h01);
        bus.fifo_full_in = 3'b000; bus.low_pkt_valid = 1'b1; bus.parity_done = 1'b0;
        step();
        check("laf_state", {7'b0, bus.laf_state}, 8'h01);
        step();
        check("laf_to_lp", {5'b0, bus.write_enb}, 8'h01);
        bus.pkt_valid = 1'b0; bus.low_pkt_valid = 1'b0;
        step(); step();

        // Timeout on port 0: pulses at 30 and 60.
        bus.fifo_empty = 3'b110;
        p1 = 0; p2 = 0;
        for (int k = 1; k <= 70; k++) begin
            step();
            if (bus.soft_reset[0]) begin
                if (p1 == 0) p1 = k;
                else if (p2 == 0) p2 = k;
            end
        end
        check("to_first", 8'(p1), 8'd30);
        check("to_second", 8'(p2), 8'd60);

        // A read at cycle 20 restarts the count.
        bus.fifo_empty = 3'b111;
        step();
        bus.fifo_empty = 3'b110;
        p1 = 0;
        for (int k = 1; k <= 60; k++) begin
            bus.read_enb = (k == 20) ? 3'b001 : 3'b000;
            step();
            if (bus.soft_reset[0] && p1 == 0) p1 = k;
        end
        bus.read_enb = 3'b000;
        check("to_restart", 8'(p1), 8'd50);

        // Soft reset aborts a wait on port 2.
        bus.fifo_empty = 3'b111;
        step();
        bus.fifo_empty = 3'b011; bus.pkt_valid = 1'b1; bus.addr = 2'b10;
        step();
        bus.pkt_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            seen = bus.soft_reset[2];
        end
        check("wte_sr_seen", {7'b0, seen}, 8'h01);
        step();
        check("wte_sr_abort", {7'b0, bus.detect_add}, 8'h01);
        bus.fifo_empty = 3'b111;

        // Reset mid-packet.
        bus.pkt_valid = 1'b1; bus.addr = 2'b01;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_mid_da", {7'b0, bus.detect_add}, 8'h01);
        check("rst_mid_wen", {5'b0, bus.write_enb}, 8'h00);
        rst = 1'b1; bus.pkt_valid = 1'b0;
        step();
        check("rst_after_wen", {5'b0, bus.write_enb}, 8'h00);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            rst               = ($urandom_range(63) != 0);
            bus.pkt_valid     = ($urandom_range(3) != 0);
            bus.addr          = 2'($urandom_range(3));
            bus.parity_done   = ($urandom_range(3) == 0);
            bus.low_pkt_valid = ($urandom_range(1) == 0);
            for (int i = 0; i < 3; i++) begin
                bus.fifo_empty[i]   = ($urandom_range(4) != 0);
                bus.fifo_full_in[i] = ($urandom_range(9) == 0);
                bus.read_enb[i]     = ($urandom_range(1) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
Control FSM for the 1x3 router. It sequences the router register block (detect_add, lfd/ld/laf/full states, rst_int_reg) and generates the per-port FIFO write enables and busy. It also runs a per-output read-timeout that soft-resets an abandoned FIFO. It sits between the input port, the register block and the three output FIFOs.

Parameters:
TIMEOUT, 30, cycles a valid output may go unread before soft_reset pulses
CNT_W, 5, width of each timeout counter (must hold TIMEOUT-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
pkt_valid  in  1  input packet valid
addr  in  2  d_in[1:0] of the input byte (destination port; 3 is invalid)
parity_done  in  1  from register block
low_pkt_valid  in  1  from register block
fifo_full_in  in  3  full flag of each output FIFO
fifo_empty  in  3  empty flag of each output FIFO
read_enb  in  3  read strobe of each output port
detect_add  out  1  state == DECODE_ADDRESS
lfd_state  out  1  state == LOAD_FIRST_DATA
ld_state  out  1  state == LOAD_DATA
full_state  out  1  state == FIFO_FULL_STATE
laf_state  out  1  state == LOAD_AFTER_FULL
rst_int_reg  out  1  state == CHECK_PARITY_ERROR
write_enb_reg  out  1  LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL
busy  out  1  high in all states except DECODE_ADDRESS and LOAD_DATA
fifo_full  out  1  fifo_full_in[addr_reg]
write_enb  out  3  one-hot of addr_reg when write_enb_reg, else 0
vld_out  out  3  ~fifo_empty, per port
soft_reset  out  3  one-cycle timeout pulse per port

Behaviour:
- Reset (rst=0 at clk edge): state=DECODE_ADDRESS, addr_reg=0, all counters=0, soft_reset=0. All state-decode outputs are Moore decodes of the state register, so detect_add=1 after reset.
- addr_reg loads addr when state is DECODE_ADDRESS, pkt_valid=1 and addr!=3. It holds otherwise.
- Transitions (evaluated each clk edge):
  DECODE_ADDRESS: pkt_valid & addr!=3 & fifo_empty[addr] -> LOAD_FIRST_DATA. pkt_valid & addr!=3 & !fifo_empty[addr] -> WAIT_TILL_EMPTY. addr==3 or !pkt_valid -> stay; the packet is dropped.
  LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
  LOAD_DATA: fifo_full -> FIFO_FULL_STATE. Else !pkt_valid -> LOAD_PARITY. Else stay.
  FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL. Else stay.
  LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS. Else low_pkt_valid -> LOAD_PARITY. Else -> LOAD_DATA.
  LOAD_PARITY -> CHECK_PARITY_ERROR.
  CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE. Else -> DECODE_ADDRESS.
  WAIT_TILL_EMPTY: fifo_empty[addr_reg] -> LOAD_FIRST_DATA. Else stay.
- Soft-reset override: in any state other than DECODE_ADDRESS, soft_reset[addr_reg]=1 forces the next state to DECODE_ADDRESS. This takes priority over every transition above.
- Timeout counter, per port i:
  - vld_out[i]=0 or read_enb[i]=1 -> counter cleared.
  - Else counter increments.
  - When the counter reaches TIMEOUT-1 with vld_out[i]=1 and read_enb[i]=0: soft_reset[i]=1 for exactly one cycle (registered) and the counter clears.
  - The first pulse lands TIMEOUT cycles after vld_out rises with no read.
- fifo_full and write_enb are combinational from addr_reg. write_enb is all-zero outside the write states.
- rst asserted mid-packet: immediate return to DECODE_ADDRESS. No write_enb on the following cycle.

Decomposition:
- Shared package router_pkg: state enum (3-bit encoding, DECODE_ADDRESS=0), ADDR_INVALID=2'b11, TIMEOUT default.
- One sub-module: router_timeout (one counter plus soft_reset pulse), instantiated three times.
- FSM and output decode stay in router_ctrl.

Test Plan:
- Port 1 empty; pkt_valid=1, addr=01, then 3 payload cycles, then pkt_valid=0 -> states DA,LFD,LD x3,LP,CPE,DA. write_enb=3'b010 during LD/LP. rst_int_reg high exactly one cycle.
- addr=11 with pkt_valid=1 -> stays DECODE_ADDRESS, write_enb=0, busy=0.
- Port 2 non-empty at header -> WAIT_TILL_EMPTY and busy=1. fifo_empty[2] rises -> LFD next cycle.
- fifo_full_in[0] asserted during LD -> FIFO_FULL_STATE. Deassert with low_pkt_valid=1, parity_done=0 -> LAF, then LP.
- fifo_empty[0]=0, read_enb[0]=0 held -> soft_reset[0] pulses one cycle at cycle 30, then again at cycle 60. read_enb at cycle 20 restarts the count.
- In WAIT_TILL_EMPTY for port 2, soft_reset[2] fires -> DECODE_ADDRESS next cycle. rst=0 in LD -> DA, counters 0.
